fp32_accum: RTL and testbench
=============================

FP32_ACCUM -- requirements
Module: fp32_accum

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the element counter.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  in_data/in_last valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port in_data  input  32  FP32 product from the fused multiplier output.
REQ-007 SHALL have port in_last  input  1  marks final element of a group.
REQ-008 SHALL have port out_valid  output  1  group sum available.
REQ-009 SHALL have port out_ready  input  1  consumer takes out_data.
REQ-010 SHALL have port out_data  output  32  FP32 group sum.
REQ-011 SHALL have port out_count  output  CNT_W  number of elements in the group.

Function
REQ-012 SHALL accumulate a stream of FP32 products into one FP32 sum per group, where a group is delimited by in_last.
REQ-013 SHALL implement states IDLE (no element held), ACCUM (partial sum held) and HOLD (result presented).
REQ-014 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in HOLD.
REQ-015 SHALL treat a beat as accepted only when in_valid && in_ready.
REQ-016 SHALL, on an accepted beat in IDLE, load in_data directly into the accumulator and set the count to 1, with no addition.
REQ-017 SHALL, on an accepted beat in ACCUM, replace the accumulator with acc+in_data in the same cycle and increment the count.
REQ-018 SHALL move IDLE->ACCUM on an accepted beat with in_last=0.
REQ-019 SHALL move IDLE/ACCUM->HOLD on an accepted beat with in_last=1, and SHALL assert out_valid in the following cycle (1-cycle latency).
REQ-020 SHALL, in HOLD, keep out_data and out_count stable until out_valid && out_ready.
REQ-021 SHALL move HOLD->IDLE on the handshake; the accumulator SHALL hold no element afterwards.
REQ-022 SHALL round the adder result to nearest, ties to even.
REQ-023 SHALL flush denormal inputs to signed zero and SHALL flush denormal results to +0.
REQ-024 SHALL return +Inf or -Inf on overflow.
REQ-025 SHALL return 0x7FC00000 when any operand is NaN, and SHALL return 0x7FC00000 for Inf + (-Inf).
REQ-026 SHALL produce 0x80000000 for an exact-zero sum only when both operands are -0, and 0x00000000 otherwise.
REQ-027 SHALL saturate out_count at all-ones and SHALL NOT wrap it.
REQ-028 SHALL leave in_valid ignored in HOLD, with no state change.

Reset
REQ-029 SHALL, while rst=1, force state IDLE, out_valid=0, out_data=0, out_count=0, clear the accumulator, and drive in_ready=1.
REQ-030 SHALL discard any partial or held group when reset is asserted mid-operation.

Verification
REQ-031 SHALL cover a basic group: beats 0x3F800000, 0x40000000, 0x40800000(last) -> out_valid one cycle after the last beat, out_data 0x40E00000, out_count 3.
REQ-032 SHALL cover cancellation: beats 0x40100000, 0xC0100000(last) -> out_data 0x00000000, out_count 2.
REQ-033 SHALL cover overflow and invalid: 0x7F7FFFFF, 0x7F7FFFFF(last) -> 0x7F800000; 0x7F800000, 0xFF800000(last) -> 0x7FC00000.
REQ-034 SHALL cover backpressure: out_ready=0 for 3 cycles after out_valid -> out_data and out_count stable, in_ready=0, extra in_valid beats ignored; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover reset mid-group: two beats accepted, then rst pulse -> out_valid=0; then a single beat 0x3F800000(last) -> out_data 0x3F800000, out_count 1.
REQ-036 SHALL cover back-to-back groups: last beat of group A and out_ready held high -> group B first beat accepted the cycle after the handshake, with no leakage of A into B.

Source files
------------

// File: rtl/fp32_accum.sv
// fp32_accum: accumulates a stream of FP32 values into one FP32 sum per group.
// A group ends with the beat that carries in_last. The sum and element count
// are presented on out_data/out_count while out_valid is high, and held until
// the consumer takes them.
//
// Adder: round to nearest even. Denormal operands are treated as signed zero,
// denormal results become +0, and overflow gives a signed infinity. Any NaN
// operand, and Inf + -Inf, give the quiet NaN 0x7FC00000.
//
// The first beat of a group is loaded as-is, with no addition.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active high
//   in_valid  in   in_data/in_last valid this cycle
//   in_ready  out  block accepts input (low while a result is held)
//   in_data   in   FP32 element
//   in_last   in   final element of the group
//   out_valid out  group sum available
//   out_ready in   consumer takes the result
//   out_data  out  FP32 group sum
//   out_count out  elements in the group, saturating at all-ones
//
// state   | meaning
// S_IDLE  | no element held
// S_ACCUM | partial sum held in acc_q
// S_HOLD  | result presented on out_data/out_count
module fp32_accum #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_HOLD  = 2'b10
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      sum;

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic              sa, sb, sx, sy;
    logic [7:0]        ea, eb, ex, ey, d;
    logic [22:0]       fa, fb, fx, fy, mant;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [26:0]       mx, my, my_sh, mask, norm;
    logic [27:0]       s;
    logic [4:0]        lz;
    logic              found, rnd_up;
    logic [24:0]       m25;
    logic signed [9:0] exp_r;
    logic [31:0]       res;

    sa = a[31];
    sb = b[31];
    ea = a[30:23];
    eb = b[30:23];
    // Denormal operands lose their fraction, leaving a signed zero.
    fa = (ea == 8'd0) ? 23'd0 : a[22:0];
    fb = (eb == 8'd0) ? 23'd0 : b[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);

    sx = sa; sy = sb; ex = ea; ey = eb; fx = fa; fy = fb;
    d = 8'd0; mx = 27'd0; my = 27'd0; my_sh = 27'd0; mask = 27'd0;
    norm = 27'd0; s = 28'd0; lz = 5'd0; found = 1'b0; rnd_up = 1'b0;
    m25 = 25'd0; exp_r = 10'sd0; mant = 23'd0; res = 32'd0;

    if (a_nan || b_nan) begin
      res = QNAN;
    end else if (a_inf && b_inf) begin
      res = (sa == sb) ? {sa, 8'hFF, 23'd0} : QNAN;
    end else if (a_inf) begin
      res = {sa, 8'hFF, 23'd0};
    end else if (b_inf) begin
      res = {sb, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      res = {sa & sb, 31'd0};
    end else if (a_zero) begin
      res = {sb, eb, fb};
    end else if (b_zero) begin
      res = {sa, ea, fa};
    end else begin
      // x is the larger magnitude; it sets the result sign and exponent.
      if ({eb, fb} > {ea, fa}) begin
        sx = sb; ex = eb; fx = fb;
        sy = sa; ey = ea; fy = fa;
      end
      d  = ex - ey;
      // Three extra low bits: guard, round, sticky.
      mx = {1'b1, fx, 3'b000};
      my = {1'b1, fy, 3'b000};
      if (d >= 8'd27) begin
        my_sh = 27'd1;
      end else begin
        mask  = (27'd1 << d) - 27'd1;
        my_sh = (my >> d) | {26'd0, |(my & mask)};
      end

      if (sx == sy) s = {1'b0, mx} + {1'b0, my_sh};
      else          s = {1'b0, mx} - {1'b0, my_sh};

      if (s == 28'd0) begin
        res = 32'd0;
      end else begin
        if (s[27]) begin
          norm  = {s[27:2], s[1] | s[0]};
          exp_r = $signed({2'b00, ex}) + 10'sd1;
        end else begin
          for (int i = 26; i >= 0; i--) begin
            if (!found && s[i]) begin
              lz    = 5'(26 - i);
              found = 1'b1;
            end
          end
          norm  = s[26:0] << lz;
          exp_r = $signed({2'b00, ex}) - $signed({5'd0, lz});
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        m25    = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        if (m25[24]) begin
          exp_r = exp_r + 10'sd1;
          mant  = m25[23:1];
        end else begin
          mant  = m25[22:0];
        end

        if (exp_r >= 10'sd255)    res = {sx, 8'hFF, 23'd0};
        else if (exp_r <= 10'sd0) res = 32'd0;
        else                      res = {sx, exp_r[7:0], mant};
      end
    end
    return res;
  endfunction

  assign sum = fp_add(acc_q, in_data);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = in_data;
          cnt_d   = CNT_W'(1);
          state_d = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d   = sum;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          acc_d   = 32'd0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        acc_d   = 32'd0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = acc_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_fp32_accum.sv
// Bench for fp32_accum: directed groups plus random groups, checked against
// a real-arithmetic reference model of the FP32 add rules.
module tb_fp32_accum;

  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = 32'd0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] grp[$];

  fp32_accum #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] dbits;
    dbits = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(dbits);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] dbits;
    int fe, m;
    logic g, st;
    dbits = $realtobits(r);
    fe = int'(dbits[62:52]) - 1023 + 127;
    m  = int'({1'b1, dbits[51:29]});
    g  = dbits[28];
    st = |dbits[27:0];
    if (g && (st || m[0])) m = m + 1;
    if (m == (1 << 24)) begin
      m  = m >> 1;
      fe = fe + 1;
    end
    if (fe >= 255) return {dbits[63], 8'hFF, 23'd0};
    if (fe <= 0)   return 32'd0;
    return {dbits[63], 8'(fe), 23'(m)};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b;
    logic a_nan, b_nan, a_inf, b_inf;
    real r;
    a = (a_in[30:23] == 8'd0) ? {a_in[31], 31'd0} : a_in;
    b = (b_in[30:23] == 8'd0) ? {b_in[31], 31'd0} : b_in;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf) return (a[31] == b[31]) ? a : 32'h7FC0_0000;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a[30:0] == 0 && b[30:0] == 0) return (a[31] && b[31]) ? 32'h8000_0000 : 32'd0;
    if (a[30:0] == 0) return b;
    if (b[30:0] == 0) return a;
    r = f2r(a) + f2r(b);
    if (r == 0.0) return 32'd0;
    return r2f(r);
  endfunction

  function automatic logic [31:0] ref_group();
    logic [31:0] acc;
    acc = grp[0];
    for (int i = 1; i < grp.size(); i++) acc = ref_add(acc, grp[i]);
    return acc;
  endfunction

  function automatic logic [31:0] rand_fp(input logic [31:0] prev);
    logic s;
    s = 1'($urandom);
    case ($urandom_range(39, 0))
      0:       return {s, 31'd0};
      1:       return {s, 8'd0, 23'($urandom) | 23'd1};
      2:       return {s, 8'hFF, 23'd0};
      3:       return {s, 8'hFF, 23'($urandom) | 23'd1};
      4, 5:    return {s, 8'hFE, 23'($urandom)};
      6, 7:    return {s, 8'($urandom_range(3, 1)), 23'($urandom)};
      8, 9, 10: return prev ^ 32'h8000_0000;
      11, 12:  return prev ^ 32'h8000_0001;
      default: return {s, 8'($urandom_range(134, 120)), 23'($urandom)};
    endcase
  endfunction

  // Sends grp as one group, then holds off the consumer for bp cycles.
  task automatic run_group(input string tag, input int bp, input int max_gap);
    logic [31:0] exp_d, exp_c;
    int n;
    n     = grp.size();
    exp_d = ref_group();
    exp_c = (n > CNT_MAX) ? CNT_MAX : n;
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) begin
          in_valid = 1'b0;
          tick();
        end
      end
      in_valid = 1'b1;
      in_data  = grp[i];
      in_last  = (i == n - 1);
      if (i == 0) check({tag, "_rdy_in"}, 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_ovalid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_count"}, 32'(out_count), exp_c);
    check({tag, "_rdy_hold"}, 32'(in_ready), 32'd0);
    for (int k = 0; k < bp; k++) begin
      in_valid  = 1'b1;
      in_data   = $urandom;
      in_last   = 1'($urandom);
      out_ready = 1'b0;
      tick();
      check({tag, "_bp_ovalid"}, 32'(out_valid), 32'd1);
      check({tag, "_bp_data"}, out_data, exp_d);
      check({tag, "_bp_count"}, 32'(out_count), exp_c);
      check({tag, "_bp_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_done_ovalid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] prev;
    int n;
    #12;
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    grp = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000};
    run_group("basic", 0, 0);
    check("basic_ref", ref_group(), 32'h40E0_0000);

    grp = '{32'h4010_0000, 32'hC010_0000};
    run_group("cancel", 0, 0);

    grp = '{32'h7F7F_FFFF, 32'h7F7F_FFFF};
    run_group("ovf", 0, 0);
    grp = '{32'h7F80_0000, 32'hFF80_0000};
    run_group("inf_inf", 0, 0);
    grp = '{32'h8000_0000, 32'h8000_0000};
    run_group("negzero", 0, 0);
    grp = '{32'h0000_0001, 32'h3F80_0000};
    run_group("denorm_in", 0, 0);

    grp = '{32'h3FC0_0000, 32'h4020_0000};
    run_group("bp", 3, 0);

    // Reset mid-group discards the partial sum.
    in_valid = 1'b1; in_data = 32'h4040_0000; in_last = 1'b0;
    tick();
    in_data = 32'h3F00_0000;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ovalid", 32'(out_valid), 32'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_count", 32'(out_count), 32'd0);
    check("midrst_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    grp = '{32'h3F80_0000};
    run_group("after_rst", 0, 0);

    // Back-to-back groups: B's first beat goes in the cycle after A's handshake.
    grp = '{32'h4120_0000, 32'h4120_0000};
    run_group("b2b_a", 0, 0);
    grp = '{32'h3F80_0000, 32'h3F80_0000};
    run_group("b2b_b", 0, 0);

    grp = '{};
    for (int i = 0; i < 9; i++) grp.push_back(32'h3F80_0000);
    run_group("sat", 1, 0);
    check("sat_ref", ref_group(), 32'h4110_0000);

    for (int g = 0; g < 150; g++) begin
      grp  = '{};
      n    = $urandom_range(10, 1);
      prev = {1'b0, 8'd127, 23'd0};
      for (int i = 0; i < n; i++) begin
        prev = rand_fp(prev);
        grp.push_back(prev);
      end
      run_group($sformatf("rnd%0d", g), $urandom_range(3, 0), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
